// File: rtl/grostl_control_serial_m_if.sv
// Control bus between the Grostl-256 compression sequencer and the rest of the
// hashing core.
//   start  : compression request from the hashing top level
//   busy   : sequencer is in a non-IDLE state
//   done   : one-cycle pulse; datapath output valid until the next start
//   wr_m   : message/state register write enable
//   wr_h   : chaining register write enable
//   sel_m  : 00 masked load, 01 round output, 10 m^h
//   sel_h  : 0 h_in, 1 m^h
//   sel_d  : 1 shifted state (column 0), 0 unshifted state
//   sel_pq : 0 = P, 1 = Q
//   rnd    : round number
//   col    : column index
// Modport master belongs to the sequencer. Modport slave belongs to the top
// level and datapath side that consumes the controls.
interface grostl_control_serial_m_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       wr_m;
  logic       wr_h;
  logic [1:0] sel_m;
  logic       sel_h;
  logic       sel_d;
  logic       sel_pq;
  logic [3:0] rnd;
  logic [2:0] col;

  modport master (
    input  start,
    output busy, done, wr_m, wr_h, sel_m, sel_h, sel_d, sel_pq, rnd, col
  );

  modport slave (
    output start,
    input  busy, done, wr_m, wr_h, sel_m, sel_h, sel_d, sel_pq, rnd, col
  );
endinterface

// File: rtl/grostl_control_serial_m.sv
// Sequencer for the masked, column-serial Grostl-256 compression datapath.
// The datapath computes f(h,m) = P(h^m) ^ Q(m) ^ h on one shared P/Q
// permutation. All datapath controls are decoded as Moore outputs from the
// registered state.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : control bus (master modport), see grostl_control_serial_m_if
//
// state  | meaning
// IDLE   | waiting for start; done pulses here for one cycle after FOLD_Q
// LOAD_P | load masked m into state register, h_in into chaining register
// XOR    | state <= m ^ h
// RUN_P  | P permutation, 2 cycles per column, 8 columns per round
// FOLD_P | h <= P(h^m) ^ h
// LOAD_Q | reload masked m into state register
// RUN_Q  | Q permutation, same schedule as RUN_P
// FOLD_Q | fold Q(m) into h; output becomes valid
module grostl_control_serial_m #(
  parameter int ROUNDS = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  grostl_control_serial_m_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_P = 3'd1,
    XOR_S  = 3'd2,
    RUN_P  = 3'd3,
    FOLD_P = 3'd4,
    LOAD_Q = 3'd5,
    RUN_Q  = 3'd6,
    FOLD_Q = 3'd7
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  state_t     state_q, state_d;
  logic       ph_q, ph_d;
  logic [2:0] col_q, col_d;
  logic [3:0] rnd_q, rnd_d;
  logic       done_q, done_d;

  logic       wr_m, wr_h, sel_h, sel_d, sel_pq;
  logic [1:0] sel_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      col_q   <= 3'd0;
      rnd_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      col_q   <= col_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    col_d   = col_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    wr_m    = 1'b0;
    wr_h    = 1'b0;
    sel_m   = 2'b10;
    sel_h   = 1'b1;
    sel_d   = 1'b0;
    sel_pq  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD_P;
      end
      LOAD_P: begin
        // sel_m=00 also makes the datapath capture fresh masks
        wr_m    = 1'b1;
        sel_m   = 2'b00;
        wr_h    = 1'b1;
        sel_h   = 1'b0;
        state_d = XOR_S;
      end
      XOR_S: begin
        wr_m    = 1'b1;
        state_d = RUN_P;
        ph_d    = 1'b0;
        col_d   = 3'd0;
        rnd_d   = 4'd0;
      end
      RUN_P, RUN_Q: begin
        sel_pq = (state_q == RUN_Q);
        if (!ph_q) begin
          sel_d = (col_q == 3'd0);
          ph_d  = 1'b1;
        end else begin
          wr_m  = 1'b1;
          sel_m = 2'b01;
          ph_d  = 1'b0;
          col_d = col_q + 3'd1;
          if (col_q == 3'd7) begin
            if (rnd_q == LAST_RND) begin
              // counters return to 0 so col/rnd read 0 outside RUN states
              state_d = (state_q == RUN_P) ? FOLD_P : FOLD_Q;
              rnd_d   = 4'd0;
            end else begin
              rnd_d = rnd_q + 4'd1;
            end
          end
        end
      end
      FOLD_P: begin
        wr_h    = 1'b1;
        state_d = LOAD_Q;
      end
      LOAD_Q: begin
        wr_m    = 1'b1;
        sel_m   = 2'b00;
        state_d = RUN_Q;
        ph_d    = 1'b0;
        col_d   = 3'd0;
        rnd_d   = 4'd0;
      end
      FOLD_Q: begin
        wr_m    = 1'b1;
        wr_h    = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.wr_m   = wr_m;
  assign bus.wr_h   = wr_h;
  assign bus.sel_m  = sel_m;
  assign bus.sel_h  = sel_h;
  assign bus.sel_d  = sel_d;
  assign bus.sel_pq = sel_pq;
  assign bus.rnd    = rnd_q;
  assign bus.col    = col_q;

endmodule
